// File: rtl/light_ctrl_pkg.sv
// Shared definitions for the traffic-light controller and its counter:
// colour encodings, FSM state enum and small state/colour helpers.
// The FLASH state only exists when FLASH_EN is defined.
`timescale 1ns/100ps
package light_ctrl_pkg;

    // One-hot lamp / load encodings: bit2 RED, bit1 YELLOW, bit0 GREEN
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_R,
        ST_RUN_R,
        ST_LOAD_G,
        ST_RUN_G,
        ST_LOAD_Y,
        ST_RUN_Y,
        ST_FAULT
`ifdef FLASH_EN
        , ST_FLASH
`endif
    } state_t;

    // Colour that follows the given one in the normal sequence
    function automatic logic [2:0] next_colour(input logic [2:0] c);
        case (c)
            RED:     next_colour = GREEN;
            GREEN:   next_colour = YELLOW;
            YELLOW:  next_colour = RED;
            default: next_colour = RED;
        endcase
    endfunction

    // Colour shown while in a LOAD/RUN state; RED for everything else
    function automatic logic [2:0] state_colour(input state_t s);
        case (s)
            ST_LOAD_G, ST_RUN_G: state_colour = GREEN;
            ST_LOAD_Y, ST_RUN_Y: state_colour = YELLOW;
            default:             state_colour = RED;
        endcase
    endfunction

    function automatic state_t load_state(input logic [2:0] c);
        case (c)
            GREEN:   load_state = ST_LOAD_G;
            YELLOW:  load_state = ST_LOAD_Y;
            default: load_state = ST_LOAD_R;
        endcase
    endfunction

    function automatic state_t run_state(input logic [2:0] c);
        case (c)
            GREEN:   run_state = ST_RUN_G;
            YELLOW:  run_state = ST_RUN_Y;
            default: run_state = ST_RUN_R;
        endcase
    endfunction

endpackage

// File: rtl/light_phase_controller_watchdog.sv
// light_watchdog: counts RUN cycles since the last counter load and flags
// when the allowed number of cycles without `last` has been used up.
// `expired` is a pure function of the count so the FSM can gate it with
// its own enable without forming a combinational loop.
`timescale 1ns/100ps
module light_watchdog
    import light_ctrl_pkg::*;
#(
    parameter int pWDOG_MAX   = 32,
    parameter int pWDOG_WIDTH = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count value seen in the last permitted RUN cycle
    localparam logic [pWDOG_WIDTH-1:0] TERM = pWDOG_WIDTH'(pWDOG_MAX - 1);

    logic [pWDOG_WIDTH-1:0] count;

    // Clear has priority; otherwise count enabled RUN cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TERM);

endmodule

// File: rtl/light_phase_controller.sv
// light_phase_controller: sequencing master for one light counter.
// Issues one-hot load pulses, enables the counter, advances
// RED -> GREEN -> YELLOW -> RED on `last`, drives the lamps and latches a
// sticky fault if the counter never reports `last`.
// Optional maintenance flashing is built only when FLASH_EN is defined.
`timescale 1ns/100ps
module light_phase_controller
    import light_ctrl_pkg::*;
#(
    parameter int pINIT_WIDTH = 3,
    parameter int pWDOG_MAX   = 32,
    parameter int pWDOG_WIDTH = 6,
    parameter int pFLASH_HALF = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_in,
    input  logic                   last,
`ifdef FLASH_EN
    input  logic                   flash,
`endif
    output logic [pINIT_WIDTH-1:0] init,
    output logic                   cnt_en,
    output logic [pINIT_WIDTH-1:0] lamp,
    output logic                   fault
);

    state_t     state;
    state_t     state_next;
    logic [2:0] colour;
    logic       wd_clear;
    logic       wd_en;
    logic       wd_expired;

    light_watchdog #(
        .pWDOG_MAX   (pWDOG_MAX),
        .pWDOG_WIDTH (pWDOG_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

`ifdef FLASH_EN
    localparam int FLASH_CW = (pFLASH_HALF > 1) ? $clog2(pFLASH_HALF) : 1;

    logic [FLASH_CW-1:0] flash_cnt;
    logic                flash_dark;

    // Flash blink timer: idle outside FLASH so every entry starts lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt  <= '0;
            flash_dark <= 1'b0;
        end else if (state != ST_FLASH) begin
            flash_cnt  <= '0;
            flash_dark <= 1'b0;
        end else if (flash_cnt == FLASH_CW'(pFLASH_HALF - 1)) begin
            flash_cnt  <= '0;
            flash_dark <= ~flash_dark;
        end else begin
            flash_cnt  <= flash_cnt + 1'b1;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; en_in low freezes LOAD/RUN in place
    always_comb begin
        state_next = state;
        colour     = state_colour(state);
        init       = '0;
        cnt_en     = 1'b0;
        lamp       = pINIT_WIDTH'(RED);
        fault      = 1'b0;
        wd_clear   = 1'b0;
        wd_en      = 1'b0;

        case (state)
            ST_IDLE: begin
                wd_clear = 1'b1;
                if (en_in) begin
                    state_next = ST_LOAD_R;
                end
            end
            ST_LOAD_R, ST_LOAD_G, ST_LOAD_Y: begin
                // `last` is stale here: the counter loads at the end of this cycle
                lamp = pINIT_WIDTH'(colour);
                if (en_in) begin
                    init       = pINIT_WIDTH'(colour);
                    cnt_en     = 1'b1;
                    wd_clear   = 1'b1;
                    state_next = run_state(colour);
                end
            end
            ST_RUN_R, ST_RUN_G, ST_RUN_Y: begin
                lamp = pINIT_WIDTH'(colour);
                if (en_in) begin
                    cnt_en = 1'b1;
                    wd_en  = 1'b1;
                    // `last` beats a simultaneous watchdog timeout
                    if (last) begin
                        state_next = load_state(next_colour(colour));
                    end else if (wd_expired) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
`ifdef FLASH_EN
            ST_FLASH: begin
                lamp     = flash_dark ? pINIT_WIDTH'(DARK) : pINIT_WIDTH'(YELLOW);
                wd_clear = 1'b1;
                if (!flash) begin
                    state_next = ST_LOAD_R;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef FLASH_EN
        // Maintenance request overrides everything except a latched fault
        if (flash && (state != ST_FAULT)) begin
            state_next = ST_FLASH;
        end
`endif
    end

endmodule

// File: tb/tb_light_phase_controller.sv
// Testbench for light_phase_controller. A behavioural light counter
// (GREEN=14, YELLOW=2, RED=17) closes the loop; a phase-length reference
// model predicts lamp/init/cnt_en/fault every cycle. Flash checks are
// built only when FLASH_EN is defined.
`timescale 1ns/100ps
module tb_light_phase_controller;

    localparam int N_RED      = 17;
    localparam int N_GREEN    = 14;
    localparam int N_YELLOW   = 2;
    localparam int WDOG_MAX   = 32;
    localparam int FLASH_HALF = 4;

    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_YELLOW = 3'b010;
    localparam logic [2:0] C_GREEN  = 3'b001;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_in;
    logic       last;
    logic       flash_req;
    logic [2:0] init;
    logic       cnt_en;
    logic [2:0] lamp;
    logic       fault;

    always #2 clk = ~clk;

    light_phase_controller #(
        .pINIT_WIDTH (3),
        .pWDOG_MAX   (WDOG_MAX),
        .pWDOG_WIDTH (6),
        .pFLASH_HALF (FLASH_HALF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_in  (en_in),
        .last   (last),
`ifdef FLASH_EN
        .flash  (flash_req),
`endif
        .init   (init),
        .cnt_en (cnt_en),
        .lamp   (lamp),
        .fault  (fault)
    );

    // ---------------- environment: behavioural light counter ----------------
    int   cnt;
    logic disc;          // counter disconnected: last tied low
    logic force_last;    // drive last high for one cycle
    logic force_load_g;  // arm force_last for LOAD_G cycles

    assign last = disc ? 1'b0 : (force_last ? 1'b1 : (cnt == 0));

    // ---------------- reference model (phase positions) ----------------
    logic [2:0] col_tab [3] = '{C_RED, C_GREEN, C_YELLOW};
    int         len_tab [3] = '{N_RED + 2, N_GREEN + 2, N_YELLOW + 2};

    bit m_started, m_flash, m_fault;
    int m_idx, m_pos, m_fcnt;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_green;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_flash   = 0;
        m_fault   = 0;
        m_idx     = 0;
        m_pos     = 0;
        m_fcnt    = 0;
    endtask

    task automatic model_outputs(output logic [2:0] e_lamp, output logic [2:0] e_init,
                                 output logic e_en, output logic e_fault);
        e_lamp = C_RED; e_init = 3'b000; e_en = 1'b0; e_fault = 1'b0;
        if (m_fault) begin
            e_fault = 1'b1;
        end else if (m_flash) begin
            e_lamp = (((m_fcnt / FLASH_HALF) % 2) == 0) ? C_YELLOW : 3'b000;
        end else if (m_started) begin
            e_lamp = col_tab[m_idx];
            e_en   = en_in;
            if (en_in && m_pos == 0) e_init = col_tab[m_idx];
        end
    endtask

    // Advance the model across one rising edge using the inputs of that cycle
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (m_fault) begin
            // sticky until reset
        end else if (flash_req) begin
            if (!m_flash) begin
                m_flash = 1;
                m_fcnt  = 0;
            end else begin
                m_fcnt++;
            end
        end else if (m_flash) begin
            m_flash = 0; m_started = 1; m_idx = 0; m_pos = 0;
        end else if (!m_started) begin
            if (en_in) begin
                m_started = 1; m_idx = 0; m_pos = 0;
            end
        end else if (en_in) begin
            m_pos++;
            if (!disc && m_pos == len_tab[m_idx]) begin
                m_idx = (m_idx + 1) % 3;
                m_pos = 0;
            end else if (m_pos == 1 + WDOG_MAX) begin
                m_fault = 1;
            end
        end
    endtask

    // ---------------- driver: one clock cycle with checks ----------------
    task automatic tick();
        logic [2:0] e_lamp, e_init, s_init;
        logic       e_en, e_fault, s_en;
        @(negedge clk);
        force_last = force_load_g && m_started && !m_flash && !m_fault && m_idx == 1 && m_pos == 0;
        #1;
        model_outputs(e_lamp, e_init, e_en, e_fault);
        chk("lamp",   32'(lamp),   32'(e_lamp));
        chk("init",   32'(init),   32'(e_init));
        chk("cnt_en", 32'(cnt_en), 32'(e_en));
        chk("fault",  32'(fault),  32'(e_fault));
        if (lamp == C_GREEN) obs_green++;
        s_init = init;
        s_en   = cnt_en;
        @(posedge clk);
        #1;
        force_last = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else begin
            case (s_init)
                C_RED:    cnt = N_RED;
                C_GREEN:  cnt = N_GREEN;
                C_YELLOW: cnt = N_YELLOW;
                default:  if (s_en && cnt != 0) cnt--;
            endcase
        end
        model_step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the model is at the given colour/position, bounded
    task automatic run_until(input int idx, input int pos, input string tag);
        for (int i = 0; i < 120; i++) begin
            if (m_started && !m_flash && !m_fault && m_idx == idx && m_pos == pos) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for phase %0d pos %0d", tag, idx, pos);
    endtask

    // Asynchronous reset between edges; outputs must drop immediately
    task automatic reset_pulse(input string tag);
        #0.5;
        rst_n = 1'b0;
        #0.5;
        model_reset();
        cnt = 0;
        chk({tag, "_lamp"},   32'(lamp),   32'(C_RED));
        chk({tag, "_init"},   32'(init),   32'(3'b000));
        chk({tag, "_cnt_en"}, 32'(cnt_en), 32'(1'b0));
        chk({tag, "_fault"},  32'(fault),  32'(1'b0));
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; en_in = 1'b0; flash_req = 1'b0;
        disc = 1'b0; force_last = 1'b0; force_load_g = 1'b0;
        cnt = 0; obs_green = 0;
        model_reset();

        // Reset values before any clock edge
        #1;
        chk("rst_lamp",   32'(lamp),   32'(C_RED));
        chk("rst_init",   32'(init),   32'(3'b000));
        chk("rst_cnt_en", 32'(cnt_en), 32'(1'b0));
        chk("rst_fault",  32'(fault),  32'(1'b0));
        ticks(2);

        // Release with en_in high: two full 39-cycle rotations and a bit
        rst_n = 1'b1;
        en_in = 1'b1;
        ticks(2 * 39 + 5);

        // Drop en_in for 5 cycles mid-GREEN with last forced in LOAD_G
        run_until(1, 0, "wait_load_g");
        obs_green    = 0;
        force_load_g = 1'b1;
        ticks(6);
        en_in = 1'b0;
        ticks(5);
        en_in = 1'b1;
        for (int i = 0; i < 40 && m_idx == 1; i++) tick();
        force_load_g = 1'b0;
        chk("green_stretched_len", 32'(obs_green), 32'(16 + 5));

        // Randomized run enable
        for (int i = 0; i < 200; i++) begin
            en_in = ($urandom_range(0, 9) < 8);
            tick();
        end
        en_in = 1'b1;

        // Asynchronous reset mid-YELLOW, then restart at RED
        run_until(2, 2, "wait_yellow");
        reset_pulse("async_yellow");
        ticks(25);

        // Counter disconnected: watchdog fault 1+32 cycles after LOAD_R
        reset_pulse("pre_wdog");
        disc = 1'b1;
        ticks(40);
        chk("fault_sticky", 32'(fault), 32'(1'b1));
        chk("fault_lamp",   32'(lamp),  32'(C_RED));
        disc = 1'b0;
        reset_pulse("post_fault");
        ticks(45);

`ifdef FLASH_EN
        // Maintenance flash during RED, then back to LOAD_R
        run_until(0, 5, "wait_red");
        flash_req = 1'b1;
        ticks(20);
        flash_req = 1'b0;
        ticks(25);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
